// File: rtl/fetch_unit_if.sv
// Instruction memory read port between the fetch stage (master) and
// instruction memory (slave): single-word request with ack.
interface fetch_unit_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads the PC, issues one memory read at a time and
// holds the returned word in ir for decode, with branch flush and halt.
//
// state | meaning
// IDLE  | halted or fresh out of reset, no request outstanding
// REQ   | mem_req high at mem_addr, waiting for mem_ack
// HOLD  | ir holds a word until decode takes it
// FLUSH | one cycle letting the PC load of a branch redirect land
module fetch_unit #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   output logic              pc_inc,
   input  logic              halt,
   input  logic              flush,
   fetch_unit_if.master      mem,
   output logic [DATA_W-1:0] ir,
   output logic [ADDR_W-1:0] ir_pc,
   output logic              ir_valid,
   input  logic              ir_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      HOLD  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   load_addr;
   logic   take;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // flush overrides everything, including an ack arriving the same cycle
   always_comb begin
      state_nxt = state;
      load_addr = 1'b0;
      take      = 1'b0;
      if (flush) begin
         state_nxt = FLUSH;
      end else begin
         case (state)
            IDLE: begin
               if (!halt) begin
                  state_nxt = REQ;
                  load_addr = 1'b1;
               end
            end
            REQ: begin
               if (mem.mem_ack) begin
                  state_nxt = HOLD;
                  take      = 1'b1;
               end
            end
            HOLD: begin
               if (ir_ready) begin
                  if (halt) begin
                     state_nxt = IDLE;
                  end else begin
                     state_nxt = REQ;
                     load_addr = 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (halt) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = REQ;
                  load_addr = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign mem.mem_req = (state == REQ);
   assign pc_inc      = take;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem.mem_addr <= '0;
         ir           <= '0;
         ir_pc        <= '0;
         ir_valid     <= 1'b0;
      end else begin
         if (load_addr) begin
            mem.mem_addr <= pc;
         end
         if (take) begin
            ir    <= mem.mem_rdata;
            ir_pc <= mem.mem_addr;
         end
         if (flush) begin
            ir_valid <= 1'b0;
         end else if (take) begin
            ir_valid <= 1'b1;
         end else if ((state == HOLD) && ir_ready) begin
            ir_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of the 16-bit program counter. It reads the PC value, issues a single-word read to instruction memory over a req/ack handshake, and holds the returned word in an instruction register for the decode stage. It pulses the PC's increment input once per accepted fetch and supports a flush for branch redirects, as well as a halt.

## Interface
- ADDR_W, 16, PC and memory address width.
- DATA_W, 16, instruction word width.

- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc  in  ADDR_W  current program counter value (PC register output).
- pc_inc  out  1  one-cycle pulse to PC inc input.
- halt  in  1  stop issuing new fetches.
- flush  in  1  branch redirect; PC ld is asserted in the same cycle.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  ADDR_W  read address (registered).
- mem_ack  in  1  memory returns data this cycle.
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1.
- ir  out  DATA_W  instruction register.
- ir_pc  out  ADDR_W  address the word in ir was fetched from.
- ir_valid  out  1  ir holds an unconsumed instruction.
- ir_ready  in  1  decode accepts ir this cycle.

## Operation
- States: IDLE, REQ, HOLD, FLUSH. Reset state is IDLE.
- Reset values: state=IDLE, mem_req=0, mem_addr=0, pc_inc=0, ir=0, ir_pc=0, ir_valid=0.
- IDLE: when halt=0, go to REQ and set mem_addr<=pc at that edge.
- REQ: mem_req=1. When mem_ack=1 and flush=0:
  - ir<=mem_rdata, ir_pc<=mem_addr, ir_valid<=1.
  - pc_inc=1 combinationally this cycle, so PC = mem_addr+1 after the edge.
  - Go to HOLD.
  - When mem_ack=0, stay in REQ with mem_addr stable.
- HOLD: mem_req=0. When ir_ready=1:
  - ir_valid<=0.
  - If halt=0, go to REQ with mem_addr<=pc. If halt=1, go to IDLE.
  - When ir_ready=0, hold ir, ir_pc and ir_valid unchanged.
- FLUSH: single cycle. It lets the PC load complete. Next state is REQ with mem_addr<=pc (the new target), or IDLE if halt=1.
- flush=1 in any state has priority over every other input:
  - Next state is FLUSH and ir_valid<=0.
  - pc_inc is forced 0.
  - A coincident mem_ack is discarded: ir is not written and no increment occurs.
- halt only takes effect at the IDLE/HOLD/FLUSH exit decisions. An outstanding REQ always completes.
- Address arithmetic is delegated to the PC. The block never adds; 0xFFFF wraps to 0x0000 in the PC.
- At most one request is outstanding. mem_req never drops in REQ until ack or flush.

## Timing
- First mem_req: the cycle after the first rising edge with reset high and halt=0 (IDLE→REQ edge).
- Ack latency: ir_valid rises at the edge that samples mem_ack=1. pc_inc is high during that same cycle.
- Minimum throughput: one instruction per 2 cycles (REQ with immediate ack, then HOLD with ir_ready=1).
- Flush to redirected request: flush cycle → FLUSH cycle → mem_req with the new address in the 3rd cycle.
- Memory wait states extend REQ indefinitely with no outputs changing.
- reset asserted mid-operation:
  - All outputs clear immediately (asynchronous).
  - A pc_inc pulse in progress is cut off.
  - After reset releases, operation restarts from IDLE.

## Test plan
- Reset release, halt=0, pc=0x0000, memory acks every REQ cycle with rdata=0x1000+addr, ir_ready=1:
  - mem_addr sequence is 0x0000, 0x0001, 0x0002.
  - ir is 0x1000, 0x1001, 0x1002 with matching ir_pc.
  - pc_inc pulses once every 2 cycles.
- mem_ack delayed 3 cycles at pc=0x0010: mem_req is held high for 4 cycles with mem_addr=0x0010 stable; exactly one pc_inc.
- ir_ready=0 for 5 cycles after a fetch: ir and ir_valid are stable, no new mem_req, no pc_inc. Releasing ir_ready restarts REQ the next cycle.
- flush in the same cycle as mem_ack, PC loaded to 0x0200:
  - No ir write and no pc_inc.
  - FLUSH for one cycle, then mem_addr=0x0200.
- pc=0xFFFF fetch: ir_pc=0xFFFF, and the next mem_addr is 0x0000.
- reset pulled low during a REQ wait: mem_req, ir_valid and pc_inc go to 0 immediately. After release, fetch resumes from the current pc.
